// File: rtl/twoof5_serial_rx.sv
// Serial 2-of-5 receiver: frames 5-bit codewords from a strobed bit line, decodes them
// to BCD and presents each one through a valid/acknowledge holding register.
module twoof5_serial_rx #(
  parameter int TIMEOUT = 8,
  parameter int TW      = 4
) (
  input  logic       CK,
  input  logic       CLR,
  input  logic       SIN,
  input  logic       SEN,
  input  logic       SYNC,
  input  logic       DACK,
  output logic [3:0] DIGIT,
  output logic [4:0] CODE,
  output logic       DVALID,
  output logic       ERR,
  output logic       OVR,
  output logic       TOUT,
  output logic       BUSY
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t          state_r, state_s;
  logic [3:0]      shreg_r, shreg_s;
  logic [2:0]      count_r, count_s;
  logic [TW-1:0]   idle_r, idle_s;
  logic            done_s, tmo_s;
  logic [4:0]      word_s;
  logic [3:0]      digit_r, digit_s;
  logic [4:0]      code_r, code_s;
  logic            dvalid_r, dvalid_s;
  logic            err_r, err_s;
  logic            ovr_r, ovr_s;
  logic            tout_r, tout_s;

  function automatic logic [3:0] decode(input logic [4:0] w);
    logic [3:0] d;
    case (w)
      5'b00011: d = 4'd1;
      5'b00101: d = 4'd2;
      5'b00110: d = 4'd3;
      5'b01001: d = 4'd4;
      5'b01010: d = 4'd5;
      5'b01100: d = 4'd6;
      5'b10001: d = 4'd7;
      5'b10010: d = 4'd8;
      5'b10100: d = 4'd9;
      5'b11000: d = 4'd0;
      default:  d = 4'hF;
    endcase
    return d;
  endfunction

  function automatic logic two_hot(input logic [4:0] w);
    logic [2:0] n;
    n = {2'b00, w[0]} + {2'b00, w[1]} + {2'b00, w[2]} + {2'b00, w[3]} + {2'b00, w[4]};
    return (n == 3'd2);
  endfunction

  // Completed word: the four buffered bits followed by the bit on the strobe edge.
  assign word_s = {shreg_r, SIN};

  // State register and framing datapath.
  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) begin
      state_r <= IDLE;
      shreg_r <= 4'b0000;
      count_r <= 3'd0;
      idle_r  <= {TW{1'b0}};
    end else begin
      state_r <= state_s;
      shreg_r <= shreg_s;
      count_r <= count_s;
      idle_r  <= idle_s;
    end
  end

  // Next-state logic: framing, resync, completion and idle timeout.
  always_comb begin
    state_s = state_r;
    shreg_s = shreg_r;
    count_s = count_r;
    idle_s  = idle_r;
    done_s  = 1'b0;
    tmo_s   = 1'b0;
    case (state_r)
      IDLE: begin
        idle_s = {TW{1'b0}};
        if (SEN && SYNC) begin
          shreg_s = {3'b000, SIN};
          count_s = 3'd1;
          state_s = SHIFT;
        end else begin
          count_s = 3'd0;
        end
      end
      SHIFT: begin
        if (SEN) begin
          idle_s = {TW{1'b0}};
          if (SYNC) begin
            shreg_s = {3'b000, SIN};
            count_s = 3'd1;
          end else if (count_r == 3'd4) begin
            done_s  = 1'b1;
            shreg_s = 4'b0000;
            count_s = 3'd0;
            state_s = IDLE;
          end else begin
            shreg_s = {shreg_r[2:0], SIN};
            count_s = count_r + 3'd1;
          end
        end else if (idle_r == TW'(TIMEOUT - 1)) begin
          tmo_s   = 1'b1;
          idle_s  = {TW{1'b0}};
          shreg_s = 4'b0000;
          count_s = 3'd0;
          state_s = IDLE;
        end else begin
          idle_s = idle_r + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output logic: holding register, handshake and sticky overrun.
  always_comb begin
    digit_s  = digit_r;
    code_s   = code_r;
    dvalid_s = dvalid_r;
    err_s    = err_r;
    ovr_s    = ovr_r;
    tout_s   = tmo_s;
    if (done_s) begin
      if (!dvalid_r || DACK) begin
        digit_s  = decode(word_s);
        code_s   = word_s;
        err_s    = ~two_hot(word_s);
        dvalid_s = 1'b1;
      end else begin
        ovr_s = 1'b1;
      end
    end else if (DACK && dvalid_r) begin
      dvalid_s = 1'b0;
    end else begin
      dvalid_s = dvalid_r;
    end
  end

  // Output registers.
  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) begin
      digit_r  <= 4'd0;
      code_r   <= 5'd0;
      dvalid_r <= 1'b0;
      err_r    <= 1'b0;
      ovr_r    <= 1'b0;
      tout_r   <= 1'b0;
    end else begin
      digit_r  <= digit_s;
      code_r   <= code_s;
      dvalid_r <= dvalid_s;
      err_r    <= err_s;
      ovr_r    <= ovr_s;
      tout_r   <= tout_s;
    end
  end

  assign DIGIT  = digit_r;
  assign CODE   = code_r;
  assign DVALID = dvalid_r;
  assign ERR    = err_r;
  assign OVR    = ovr_r;
  assign TOUT   = tout_r;
  assign BUSY   = (state_r == SHIFT);

endmodule
